// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one core request at a time, drives a single-cycle
// memory access, and returns extended load data or an alignment/legality error.

package riscv_lsu_pkg;
    typedef enum logic [1:0] {
        MASK_B = 2'd0,
        MASK_H = 2'd1,
        MASK_X = 2'd2
    } mask_sel_t;
endpackage

module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [WORD_LENGTH-1:0] req_addr,
    input  logic [WORD_LENGTH-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_LENGTH-1:0] resp_rdata,
    output logic                   resp_err,
    output logic [WORD_LENGTH-1:0] addr,
    output logic                   write_en,
    output logic [WORD_LENGTH-1:0] wdata,
    output mask_sel_t              ram_mask_sel,
    input  logic [WORD_LENGTH-1:0] dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
    logic [WORD_LENGTH-1:0] rdata_q, rdata_d;

    logic                   req_illegal;
    logic                   req_misaligned;
    logic [WORD_LENGTH-1:0] load_ext;

    // Legality and alignment are judged on the live request so the error
    // path can be chosen at the acceptance edge.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b0;
        endcase
    end

    always_comb begin
        req_misaligned = 1'b0;
        case (req_funct3)
            3'b001, 3'b101: req_misaligned = req_addr[0];
            3'b010:         req_misaligned = (req_addr[1:0] != 2'b00);
            default:        req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        load_ext = dout;
        case (funct3_q)
            3'b000:  load_ext = {{(WORD_LENGTH-8){dout[7]}}, dout[7:0]};
            3'b100:  load_ext = {{(WORD_LENGTH-8){1'b0}}, dout[7:0]};
            3'b001:  load_ext = {{(WORD_LENGTH-16){dout[15]}}, dout[15:0]};
            3'b101:  load_ext = {{(WORD_LENGTH-16){1'b0}}, dout[15:0]};
            default: load_ext = dout;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    state_d  = (req_illegal || req_misaligned) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = we_q ? '0 : load_ext;
                state_d = RESP;
            end
            RESP, ERR: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // The memory bus is only live during ACCESS; the write strobe is also
    // gated by reset so an abort cannot leak a write at that edge.
    always_comb begin
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = '0;
        addr         = '0;
        wdata        = '0;
        write_en     = 1'b0;
        ram_mask_sel = MASK_X;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            ACCESS: begin
                addr     = addr_q;
                wdata    = wdata_q;
                write_en = we_q && !rst;
                case (funct3_q[1:0])
                    2'b00:   ram_mask_sel = MASK_B;
                    2'b01:   ram_mask_sel = MASK_H;
                    default: ram_mask_sel = MASK_X;
                endcase
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu with a byte-addressed memory model and
// hand-computed expected values.

module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addr;
    logic        write_en;
    logic [31:0] wdata;
    mask_sel_t   ram_mask_sel;
    logic [31:0] dout;

    int vectorCount = 0;
    int missCount   = 0;
    int writeCount  = 0;
    int respSeen    = 0;

    logic [7:0] mem [0:1023];

    riscv_lsu #(.WORD_LENGTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .addr         (addr),
        .write_en     (write_en),
        .wdata        (wdata),
        .ram_mask_sel (ram_mask_sel),
        .dout         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
    endfunction

    assign dout = memWord(addr);

    // Memory model writes on the clock edge according to the access width.
    always @(posedge clk) begin
        if (write_en) begin
            writeCount = writeCount + 1;
            mem[addr[9:0]] = wdata[7:0];
            if (ram_mask_sel != MASK_B) mem[addr[9:0] + 10'd1] = wdata[15:8];
            if (ram_mask_sel == MASK_X) begin
                mem[addr[9:0] + 10'd2] = wdata[23:16];
                mem[addr[9:0] + 10'd3] = wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid) respSeen = respSeen + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount = vectorCount + 1;
        if (actual !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request in IDLE and returns just after the acceptance edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        checkOutput("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input mask_sel_t expMask, input logic [31:0] expRdata);
        int w0;
        w0 = writeCount;
        applyStimulus(we, f3, a, wd);
        @(negedge clk);
        checkOutput({tag, "_acc_addr"}, addr, a);
        checkOutput({tag, "_acc_mask"}, 32'(ram_mask_sel), 32'(expMask));
        checkOutput({tag, "_acc_wdata"}, wdata, wd);
        checkOutput({tag, "_acc_we"}, {31'b0, write_en}, {31'b0, we});
        checkOutput({tag, "_acc_rvalid"}, {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
        checkOutput({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, expRdata);
        checkOutput({tag, "_resp_bus_we"}, {31'b0, write_en}, 32'd0);
        checkOutput({tag, "_writes"}, 32'(writeCount - w0), we ? 32'd1 : 32'd0);
        @(negedge clk);
        checkOutput({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_idle_rvalid"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic doError(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        int w0;
        w0 = writeCount;
        applyStimulus(we, f3, a, wd);
        @(negedge clk);
        checkOutput({tag, "_err_valid"}, {31'b0, resp_valid}, 32'd1);
        checkOutput({tag, "_err_flag"}, {31'b0, resp_err}, 32'd1);
        checkOutput({tag, "_err_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_err_we"}, {31'b0, write_en}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_err_idle"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_err_writes"}, 32'(writeCount - w0), 32'd0);
    endtask

    initial begin
        int w0;
        int r0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h200] = 8'hF0;
        mem[10'h201] = 8'h80;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_addr", addr, 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_write_en", {31'b0, write_en}, 32'd0);
        checkOutput("rst_mask", 32'(ram_mask_sel), 32'(MASK_X));

        doAccess("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, MASK_X, 32'h0);
        checkOutput("mem100_after_sw", memWord(32'h100), 32'hDEADBEEF);
        doAccess("lw100", 1'b0, 3'b010, 32'h100, 32'h0, MASK_X, 32'hDEADBEEF);

        doAccess("lb200", 1'b0, 3'b000, 32'h200, 32'h0, MASK_B, 32'hFFFFFFF0);
        doAccess("lbu200", 1'b0, 3'b100, 32'h200, 32'h0, MASK_B, 32'h000000F0);
        doAccess("lh200", 1'b0, 3'b001, 32'h200, 32'h0, MASK_H, 32'hFFFF80F0);
        doAccess("lhu200", 1'b0, 3'b101, 32'h200, 32'h0, MASK_H, 32'h000080F0);
        doAccess("lb201", 1'b0, 3'b000, 32'h201, 32'h0, MASK_B, 32'hFFFFFF80);

        doAccess("sb103", 1'b1, 3'b000, 32'h103, 32'h12345678, MASK_B, 32'h0);
        doAccess("lw100b", 1'b0, 3'b010, 32'h100, 32'h0, MASK_X, 32'h78ADBEEF);

        doError("lw102", 1'b0, 3'b010, 32'h102, 32'h0);
        doError("sh101", 1'b1, 3'b001, 32'h101, 32'hAAAA5555);
        doError("f3_011", 1'b0, 3'b011, 32'h100, 32'h0);
        doError("sbu", 1'b1, 3'b100, 32'h100, 32'h11223344);
        doError("f3_110", 1'b0, 3'b110, 32'h100, 32'h0);
        checkOutput("mem100_after_errs", memWord(32'h100), 32'h78ADBEEF);

        // Response back-pressure with a competing request that must be ignored.
        w0 = writeCount;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h200, 32'h0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h300;
        req_wdata  = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("stall_rdata", resp_rdata, 32'h000080F0);
            checkOutput("stall_err", {31'b0, resp_err}, 32'd0);
            checkOutput("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("handshake_idle", {31'b0, req_ready}, 32'd1);
        checkOutput("handshake_rvalid", {31'b0, resp_valid}, 32'd0);
        checkOutput("handshake_we", {31'b0, write_en}, 32'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ignored_writes", 32'(writeCount - w0), 32'd0);
        checkOutput("ignored_mem300", memWord(32'h300), 32'h0);
        checkOutput("ignored_idle", {31'b0, req_ready}, 32'd1);

        // Reset during a store's ACCESS cycle aborts it with no write or response.
        w0 = writeCount;
        r0 = respSeen;
        applyStimulus(1'b1, 3'b010, 32'h100, 32'h11111111);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_we", {31'b0, write_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle", {31'b0, req_ready}, 32'd1);
        checkOutput("abort_rvalid", {31'b0, resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort_writes", 32'(writeCount - w0), 32'd0);
        checkOutput("abort_resp_seen", 32'(respSeen - r0), 32'd0);
        checkOutput("abort_mem100", memWord(32'h100), 32'h78ADBEEF);
        doAccess("lw100c", 1'b0, 3'b010, 32'h100, 32'h0, MASK_X, 32'h78ADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 32, giving the data and address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a core request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: the RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port req_addr, input, WORD_LENGTH bits: the byte address.
REQ-009 The block SHALL have port req_wdata, input, WORD_LENGTH bits: the store data, LSB-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the core accepts the response.
REQ-012 The block SHALL have port resp_rdata, output, WORD_LENGTH bits: the extended load data; 0 for stores and errors.
REQ-013 The block SHALL have port resp_err, output, 1 bit: the request was misaligned or illegal; no memory access was made.
REQ-014 The block SHALL have port addr, output, WORD_LENGTH bits: the memory byte address.
REQ-015 The block SHALL have port write_en, output, 1 bit: the memory write strobe.
REQ-016 The block SHALL have port wdata, output, WORD_LENGTH bits: the memory write data.
REQ-017 The block SHALL have port ram_mask_sel, output, MASK_SEL: the memory access width (MASK_B, MASK_H or MASK_X).
REQ-018 The block SHALL have port dout, input, WORD_LENGTH bits: the memory read data, little-endian bytes addr..addr+3, valid combinationally in the same cycle.

Function
REQ-019 The block SHALL implement an FSM with the states IDLE, ACCESS, RESP and ERR.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted when req_valid and req_ready are both 1; at acceptance the block SHALL register req_we, req_funct3, req_addr and req_wdata.
REQ-022 An accepted request SHALL be illegal when it has funct3 011, 110 or 111, or when it is a store with funct3 100 or 101.
REQ-023 An accepted request SHALL be misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-024 On an illegal or misaligned request, the FSM SHALL go IDLE->ERR; otherwise it SHALL go IDLE->ACCESS.
REQ-025 ACCESS SHALL last exactly one cycle, then the FSM SHALL go ->RESP.
REQ-026 In ACCESS, addr SHALL equal the captured address, ram_mask_sel SHALL be MASK_B for B/BU, MASK_H for H/HU and MASK_X for W, and wdata SHALL equal the captured wdata.
REQ-027 In ACCESS, write_en SHALL be 1 for a store and 0 for a load, and SHALL be forced to 0 whenever rst=1.
REQ-028 Outside ACCESS, addr, wdata and write_en SHALL be 0 and ram_mask_sel SHALL be MASK_X.
REQ-029 For a load in ACCESS, the block SHALL register dout at the end of the cycle and extend it as follows: B sign-extends [7:0]; BU zero-extends [7:0]; H sign-extends [15:0]; HU zero-extends [15:0]; W passes all 32 bits.
REQ-030 In RESP, resp_valid SHALL be 1, resp_err 0, and resp_rdata the extended value (0 for stores).
REQ-031 In ERR, resp_valid SHALL be 1, resp_err 1 and resp_rdata 0, and no memory write SHALL occur.
REQ-032 In RESP or ERR, resp_valid SHALL stay 1 with resp_rdata and resp_err stable until resp_ready=1; the FSM SHALL then go ->IDLE in the next cycle.
REQ-033 Latency SHALL be as follows with resp_ready held at 1: acceptance at cycle N, ACCESS at N+1, resp_valid at N+2, req_ready again at N+3.
REQ-034 For an error with resp_ready held at 1, resp_valid SHALL appear at N+1.
REQ-035 req_valid asserted outside IDLE SHALL be ignored, and no new request SHALL be accepted in the same cycle as a response handshake.
REQ-036 Address arithmetic SHALL use WORD_LENGTH bits and wrap modulo 2^WORD_LENGTH, and the block SHALL perform no range checking.

Reset
REQ-037 When rst=1 at a rising edge, the FSM SHALL go to IDLE and all captured registers and resp_rdata SHALL be cleared to 0.
REQ-038 After reset, the outputs SHALL be req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, addr=0, wdata=0, write_en=0 and ram_mask_sel=MASK_X.
REQ-039 A reset asserted in any state SHALL abort the operation, with no response issued and no write occurring at that edge.

Verification
REQ-040 The bench SHALL cover this scenario: SW addr=0x100 wdata=0xDEADBEEF, then LW addr=0x100 -> write_en for exactly one cycle with MASK_X; the load responds with resp_rdata=0xDEADBEEF at acceptance+2.
REQ-041 The bench SHALL cover this scenario: memory word at 0x200 holds 0x000080F0; LB 0x200 -> 0xFFFFFFF0; LBU 0x200 -> 0x000000F0; LH 0x200 -> 0xFFFF80F0; LHU 0x200 -> 0x000080F0.
REQ-042 The bench SHALL cover this scenario: SB addr=0x103 wdata=0x12345678 -> MASK_B at addr 0x103; a following LW 0x100 after the REQ-040 store -> 0x78ADBEEF.
REQ-043 The bench SHALL cover this scenario: LW addr=0x102 and SH addr=0x101 -> resp_err=1 and resp_rdata=0 at acceptance+1, with write_en never asserted.
REQ-044 The bench SHALL cover this scenario: funct3=011 and store funct3=100 -> resp_err=1.
REQ-045 The bench SHALL cover this scenario: resp_ready held at 0 for 5 cycles during a load -> resp_valid and resp_rdata stable throughout, and req_ready=0 with a concurrent req_valid ignored.
REQ-046 The bench SHALL cover this scenario: rst asserted during a store's ACCESS cycle -> the memory is unchanged, the FSM is in IDLE, and resp_valid is never asserted.
